cfg_chain_routing_mux: RTL and testbench

- Parametrised N-input routing multiplexer for the FPGA fabric, configured through a serial configuration chain (ccff_head / ccff_tail).
- A shadow shift register is loaded serially. On a validated commit it is copied into a one-hot active select register, so the datapath never sees partial configuration.
- Successor to the fixed-size TGATE/buffer mux structures: generalised input count, optional inverting output stage, one-hot legality checking, and a shift-count check.

---
 rtl/fabric_cfg_pkg.sv | 31 +++
 rtl/cfg_shadow_chain.sv | 59 +++++
 rtl/cfg_chain_routing_mux.sv | 79 +++++++
 tb/tb_cfg_chain_routing_mux.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_cfg_pkg.sv
// Shared helpers and encodings for serially configured fabric elements.
package fabric_cfg_pkg;

  // Largest input count the legality helper accepts.
  localparam int unsigned MAX_N_IN = 64;

  // Output stage modes, reserved for future configuration mode bits.
  typedef enum logic [1:0] {
    OUT_MODE_BUF = 2'd0,
    OUT_MODE_INV = 2'd1
  } out_mode_e;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

  // True when at most one bit of v is set.
  function automatic logic onehot_or_zero(input logic [MAX_N_IN-1:0] v);
    int unsigned ones;
    ones = 0;
    for (int unsigned i = 0; i < MAX_N_IN; i++) begin
      ones = ones + 32'(v[i]);
    end
    return (ones <= 1);
  endfunction

endpackage

// File: rtl/cfg_shadow_chain.sv
// Serial shadow shift register with saturating shift counter and tail flop.
module cfg_shadow_chain
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned N_IN = 4
) (
  input  logic            prog_clk,
  input  logic            prog_reset,
  input  logic            shift_en_i,
  input  logic            clear_i,
  input  logic            head_i,
  output logic [N_IN-1:0] shadow_o,
  output logic            full_o,
  output logic            tail_o
);

  localparam int unsigned CW = cnt_width(N_IN);
  localparam logic [CW-1:0] CNT_MAX = CW'(N_IN);

  logic [N_IN-1:0] shadow_q, shadow_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_q, full_d;
  logic            tail_q, tail_d;

  // Next state: shift in at LSB, tail takes the pre-shift MSB, counter saturates.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    tail_d   = tail_q;
    if (shift_en_i) begin
      shadow_d = {shadow_q[N_IN-2:0], head_i};
      tail_d   = shadow_q[N_IN-1];
      cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    end else if (clear_i) begin
      cnt_d = '0;
    end
    full_d = (cnt_d == CNT_MAX);
  end

  // Chain state registers.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      tail_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      tail_q   <= tail_d;
    end
  end

  assign shadow_o = shadow_q;
  assign full_o   = full_q;
  assign tail_o   = tail_q;

endmodule

// File: rtl/cfg_chain_routing_mux.sv
// N-input routing mux whose one-hot select is loaded through a config chain.
module cfg_chain_routing_mux
  import fabric_cfg_pkg::*;
#(
  parameter int unsigned N_IN        = 4,
  parameter int unsigned DEFAULT_SEL = 0,
  parameter int unsigned OUT_INV     = 0
) (
  input  logic            prog_clk,
  input  logic            prog_reset,
  input  logic            ccff_head,
  output logic            ccff_tail,
  input  logic            cfg_en,
  input  logic            cfg_commit,
  input  logic [N_IN-1:0] in,
  output logic            out,
  output logic            out_en,
  output logic            cfg_err,
  output logic            cfg_full
);

  localparam logic [N_IN-1:0] ACTIVE_RST  = N_IN'(1) << DEFAULT_SEL;
  localparam logic            OUT_INV_BIT = 1'(OUT_INV);

  logic [N_IN-1:0] shadow;
  logic            full;
  logic            commit_ok;
  logic [N_IN-1:0] active_q, active_d;
  logic            err_q, err_d;

  cfg_shadow_chain #(
    .N_IN (N_IN)
  ) u_chain (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .shift_en_i (cfg_en),
    .clear_i    (cfg_commit & ~cfg_en),
    .head_i     (ccff_head),
    .shadow_o   (shadow),
    .full_o     (full),
    .tail_o     (ccff_tail)
  );

  assign commit_ok = full & onehot_or_zero(MAX_N_IN'(shadow));

  // Commit arbitration: a commit during a shift is a protocol error and is dropped.
  always_comb begin
    active_d = active_q;
    err_d    = err_q;
    if (cfg_en && cfg_commit) begin
      err_d = 1'b1;
    end else if (cfg_commit) begin
      if (commit_ok) begin
        active_d = shadow;
        err_d    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Active select and sticky error registers.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      active_q <= ACTIVE_RST;
      err_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  // Output stage: all-zero select drives the idle level instead of high-Z.
  assign out      = (|(active_q & in)) ^ OUT_INV_BIT;
  assign out_en   = |active_q;
  assign cfg_err  = err_q;
  assign cfg_full = full;

endmodule

// File: tb/tb_cfg_chain_routing_mux.sv
// Directed self-checking bench for cfg_chain_routing_mux (plain and inverting builds).
module tb_cfg_chain_routing_mux;

  logic       prog_clk;
  logic       prog_reset;
  logic       ccff_head;
  logic       cfg_en;
  logic       cfg_commit;
  logic [3:0] in;

  logic ccff_tail, out, out_en, cfg_err, cfg_full;
  logic ccff_tail_i, out_i, out_en_i, cfg_err_i, cfg_full_i;

  int total = 0;
  int bad   = 0;

  cfg_chain_routing_mux #(.N_IN(4), .DEFAULT_SEL(0), .OUT_INV(0)) dut (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .ccff_head  (ccff_head),
    .ccff_tail  (ccff_tail),
    .cfg_en     (cfg_en),
    .cfg_commit (cfg_commit),
    .in         (in),
    .out        (out),
    .out_en     (out_en),
    .cfg_err    (cfg_err),
    .cfg_full   (cfg_full)
  );

  cfg_chain_routing_mux #(.N_IN(4), .DEFAULT_SEL(0), .OUT_INV(1)) dut_inv (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .ccff_head  (ccff_head),
    .ccff_tail  (ccff_tail_i),
    .cfg_en     (cfg_en),
    .cfg_commit (cfg_commit),
    .in         (in),
    .out        (out_i),
    .out_en     (out_en_i),
    .cfg_err    (cfg_err_i),
    .cfg_full   (cfg_full_i)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_reset();
    prog_reset = 1'b1; cfg_en = 1'b0; cfg_commit = 1'b0; ccff_head = 1'b0;
    tick();
    prog_reset = 1'b0;
  endtask

  // Shift four bits, MSB first.
  task automatic shift4(input logic [3:0] v);
    cfg_en = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      ccff_head = v[i];
      tick();
    end
    cfg_en = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    in = 4'b0001;
    do_reset();
    total++; if (out !== 1'b1)       begin bad++; $display("FAIL reset_out got=%b exp=1", out); end
    total++; if (out_en !== 1'b1)    begin bad++; $display("FAIL reset_out_en got=%b exp=1", out_en); end
    total++; if (cfg_err !== 1'b0)   begin bad++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    total++; if (cfg_full !== 1'b0)  begin bad++; $display("FAIL reset_full got=%b exp=0", cfg_full); end
    total++; if (ccff_tail !== 1'b0) begin bad++; $display("FAIL reset_tail got=%b exp=0", ccff_tail); end
    in = 4'b0010;
    #1;
    total++; if (out !== 1'b0)       begin bad++; $display("FAIL reset_sel0_only got=%b exp=0", out); end
  endtask

  task automatic test_shift_commit();
    shift4(4'b1000);
    total++; if (cfg_full !== 1'b1) begin bad++; $display("FAIL full_before_commit got=%b exp=1", cfg_full); end
    in = 4'b1000;
    #1;
    total++; if (out !== 1'b0)      begin bad++; $display("FAIL active_before_commit got=%b exp=0", out); end
    commit();
    total++; if (out !== 1'b1)      begin bad++; $display("FAIL commit_out got=%b exp=1", out); end
    total++; if (cfg_err !== 1'b0)  begin bad++; $display("FAIL commit_err got=%b exp=0", cfg_err); end
    total++; if (cfg_full !== 1'b0) begin bad++; $display("FAIL commit_clears_count got=%b exp=0", cfg_full); end
    in = 4'b0111;
    #1;
    total++; if (out !== 1'b0)      begin bad++; $display("FAIL commit_sel3_only got=%b exp=0", out); end
  endtask

  task automatic test_illegal_and_zero();
    shift4(4'b0110);
    commit();
    in = 4'b1000;
    #1;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL twohot_err got=%b exp=1", cfg_err); end
    total++; if (out !== 1'b1)     begin bad++; $display("FAIL twohot_active_kept got=%b exp=1", out); end
    shift4(4'b0000);
    commit();
    in = 4'b1111;
    #1;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL zero_commit_err got=%b exp=0", cfg_err); end
    total++; if (out_en !== 1'b0)  begin bad++; $display("FAIL zero_out_en got=%b exp=0", out_en); end
    total++; if (out !== 1'b0)     begin bad++; $display("FAIL zero_out got=%b exp=0", out); end
  endtask

  task automatic test_short_and_collision();
    // Only three bits of 0010: count short, select stays all-zero.
    cfg_en = 1'b1;
    ccff_head = 1'b0; tick();
    ccff_head = 1'b0; tick();
    ccff_head = 1'b1; tick();
    cfg_en = 1'b0;
    total++; if (cfg_full !== 1'b0) begin bad++; $display("FAIL short_full got=%b exp=0", cfg_full); end
    commit();
    total++; if (cfg_err !== 1'b1)  begin bad++; $display("FAIL short_err got=%b exp=1", cfg_err); end
    total++; if (out_en !== 1'b0)   begin bad++; $display("FAIL short_active_kept got=%b exp=0", out_en); end
    // Legal commit of 0001 clears the error.
    shift4(4'b0001);
    commit();
    in = 4'b0001;
    #1;
    total++; if (cfg_err !== 1'b0)  begin bad++; $display("FAIL relegal_err got=%b exp=0", cfg_err); end
    total++; if (out !== 1'b1)      begin bad++; $display("FAIL relegal_out got=%b exp=1", out); end
    // Shift and commit together: shift happens (shadow 0011, count 1), commit dropped.
    cfg_en = 1'b1; cfg_commit = 1'b1; ccff_head = 1'b1;
    tick();
    cfg_en = 1'b0; cfg_commit = 1'b0;
    total++; if (cfg_err !== 1'b1)  begin bad++; $display("FAIL collide_err got=%b exp=1", cfg_err); end
    total++; if (out !== 1'b1)      begin bad++; $display("FAIL collide_active_kept got=%b exp=1", out); end
    // Three more zeros: four shifts total gives full, shadow 1000.
    cfg_en = 1'b1; ccff_head = 1'b0;
    tick(); tick(); tick();
    cfg_en = 1'b0;
    total++; if (cfg_full !== 1'b1) begin bad++; $display("FAIL collide_shift_counted got=%b exp=1", cfg_full); end
    commit();
    in = 4'b1000;
    #1;
    total++; if (out !== 1'b1)      begin bad++; $display("FAIL collide_then_commit_out got=%b exp=1", out); end
    total++; if (cfg_err !== 1'b0)  begin bad++; $display("FAIL collide_then_commit_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_pass_through();
    logic [4:0] pat;
    pat = 5'b01101;  // pat[0] first: sequence 1,0,1,1,0
    do_reset();
    cfg_en = 1'b1;
    // Bit driven before edge i sits on the tail after edge i+4 (five cycles later).
    for (int i = 0; i < 9; i++) begin
      ccff_head = (i < 5) ? pat[i] : 1'b0;
      tick();
      if (i < 4) begin
        total++; if (ccff_tail !== 1'b0) begin bad++; $display("FAIL pass_prefill_%0d got=%b exp=0", i, ccff_tail); end
      end else begin
        total++; if (ccff_tail !== pat[i-4]) begin bad++; $display("FAIL pass_bit_%0d got=%b exp=%b", i - 4, ccff_tail, pat[i-4]); end
      end
    end
    cfg_en = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    cfg_en = 1'b1; cfg_commit = 1'b1; ccff_head = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick(); tick();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL mid_err_set got=%b exp=1", cfg_err); end
    // Shadow holds 0111, count 3: reset with shift still asserted.
    prog_reset = 1'b1;
    tick();
    prog_reset = 1'b0; cfg_en = 1'b0;
    in = 4'b0001;
    #1;
    total++; if (cfg_err !== 1'b0)   begin bad++; $display("FAIL mid_reset_err got=%b exp=0", cfg_err); end
    total++; if (cfg_full !== 1'b0)  begin bad++; $display("FAIL mid_reset_full got=%b exp=0", cfg_full); end
    total++; if (ccff_tail !== 1'b0) begin bad++; $display("FAIL mid_reset_tail got=%b exp=0", ccff_tail); end
    total++; if (out !== 1'b1)       begin bad++; $display("FAIL mid_reset_out got=%b exp=1", out); end
    // Cleared shadow must emit only zeros.
    cfg_en = 1'b1; ccff_head = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (ccff_tail !== 1'b0) begin bad++; $display("FAIL mid_reset_shadow_%0d got=%b exp=0", i, ccff_tail); end
    end
    cfg_en = 1'b0;
  endtask

  task automatic test_out_inv();
    in = 4'b0000;
    do_reset();
    total++; if (out_i !== 1'b1)    begin bad++; $display("FAIL inv_reset_out got=%b exp=1", out_i); end
    total++; if (out_en_i !== 1'b1) begin bad++; $display("FAIL inv_reset_out_en got=%b exp=1", out_en_i); end
    in = 4'b0001;
    #1;
    total++; if (out_i !== 1'b0)    begin bad++; $display("FAIL inv_sel_out got=%b exp=0", out_i); end
    shift4(4'b0000);
    commit();
    total++; if (out_en_i !== 1'b0) begin bad++; $display("FAIL inv_zero_out_en got=%b exp=0", out_en_i); end
    in = 4'b1111;
    #1;
    total++; if (out_i !== 1'b1)    begin bad++; $display("FAIL inv_zero_out got=%b exp=1", out_i); end
  endtask

  initial begin
    prog_reset = 1'b1; ccff_head = 1'b0; cfg_en = 1'b0; cfg_commit = 1'b0; in = '0;
    test_reset();
    test_shift_commit();
    test_illegal_and_zero();
    test_short_and_collision();
    test_pass_through();
    test_reset_mid_shift();
    test_out_inv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
